// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_pkg
// Description : Shared state encoding and default sizes for reg_dump_reader.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 32;
    localparam int NUM_REGS       = 32;
    localparam int STATE_W        = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_READ   = 3'd1;
    localparam state_t S_SEND   = 3'd2;
    localparam state_t S_FINISH = 3'd3;
    localparam state_t S_CSUM   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/reg_dump_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_out_stage
// Description : Beat output register; holds a loaded beat until valid&&ready.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_out_stage #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_index,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_index,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_index;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // Payload only changes on a load, so it stays frozen through stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_index <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_index <= i_index;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_index = r_index;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_reader
// Description : Walks FIRST_REG..LAST_REG through one bank read port and
//               streams {index, value} beats; stalls the CPU while dumping.
//               Optional checksum beat: define REG_DUMP_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = NUM_REGS - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rs_addr,
    input  logic [DATA_W-1:0] rs_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              hold_cpu,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_FIRST_ADDR = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(LAST_REG);

    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > (2**ADDR_W) - 1) begin : g_bad_range
            $error("reg_dump_reader: need 0 <= FIRST_REG <= LAST_REG <= 2**ADDR_W-1");
        end
    endgenerate

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_rs_addr;

    logic              w_valid;
    logic              w_handshake;
    logic              w_at_last;
    logic              w_done;
    logic              w_busy;
    logic              w_start_dump;
    logic              w_inc_addr;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_index;
    logic [DATA_W-1:0] w_load_data;
    logic              w_load_last;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
`endif

    assign w_handshake = w_valid && dump_ready;
    assign w_at_last   = (r_rs_addr == c_LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                w_next_state = S_SEND;
            end
            S_SEND: begin
                if (w_handshake) begin
                    if (w_at_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        w_next_state = S_CSUM;
`else
                        w_next_state = S_FINISH;
`endif
                    end else begin
                        w_next_state = S_READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (w_handshake) begin
                    w_next_state = S_FINISH;
                end
            end
`endif
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // CSUM spends its first cycle loading the checksum beat, then waits on it
    // exactly like SEND, so valid still drops on every handshake.
    always_comb begin
        w_done       = (r_state == S_FINISH);
        w_busy       = (r_state != S_IDLE);
        w_start_dump = (r_state == S_IDLE) && start;
        w_inc_addr   = (r_state == S_SEND) && w_handshake && !w_at_last;
        w_load       = (r_state == S_READ);
        w_load_index = r_rs_addr;
        w_load_data  = rs_data;
`ifdef REG_DUMP_CHECKSUM_EN
        w_load_last  = 1'b0;
        if (r_state == S_CSUM && !w_valid) begin
            w_load       = 1'b1;
            w_load_index = '0;
            w_load_data  = r_csum;
            w_load_last  = 1'b1;
        end
`else
        w_load_last  = w_at_last;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs_addr <= '0;
        end else if (w_start_dump) begin
            r_rs_addr <= c_FIRST_ADDR;
        end else if (w_inc_addr) begin
            r_rs_addr <= r_rs_addr + ADDR_W'(1);
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_start_dump) begin
            r_csum <= '0;
        end else if (r_state == S_READ) begin
            r_csum <= r_csum ^ rs_data;
        end
    end
`endif

    reg_dump_out_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_index (w_load_index),
        .i_data  (w_load_data),
        .i_last  (w_load_last),
        .i_ready (dump_ready),
        .o_valid (w_valid),
        .o_index (dump_index),
        .o_data  (dump_data),
        .o_last  (dump_last)
    );

    assign rs_addr    = r_rs_addr;
    assign dump_valid = w_valid;
    assign busy       = w_busy;
    assign hold_cpu   = w_busy;
    assign done       = w_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_reader
// Description : Randomized self-checking bench for reg_dump_reader (full-range
//               and single-register instances); honours REG_DUMP_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int N_REGS = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              dump_ready = 1'b1;
    logic [ADDR_W-1:0] rs_addr;
    logic [DATA_W-1:0] rs_data;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              hold_cpu;
    logic              busy;
    logic              done;

    logic              start_s = 1'b0;
    logic              ready_s = 1'b1;
    logic [ADDR_W-1:0] rs_addr_s;
    logic [DATA_W-1:0] rs_data_s;
    logic              valid_s;
    logic [ADDR_W-1:0] index_s;
    logic [DATA_W-1:0] data_s;
    logic              last_s;
    logic              hold_s;
    logic              busy_s;
    logic              done_s;

    logic [DATA_W-1:0] bank [N_REGS];
    assign rs_data   = bank[rs_addr];
    assign rs_data_s = bank[rs_addr_s];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  rnd_ready = 1'b0;
    int  cyc = 0;
    int  m_beats = 0;
    int  done_cnt = 0;
    int  first_read_cyc = 0;
    int  last_hs_cyc = 0;
    int  done_cyc = 0;
    bit  prev_stall = 1'b0;
    bit  prev_busy = 1'b0;
    beat_t prev_beat;

    reg_dump_reader u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_index (dump_index),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .hold_cpu   (hold_cpu),
        .busy       (busy),
        .done       (done)
    );

    reg_dump_reader #(.FIRST_REG(7), .LAST_REG(7)) u_single (
        .clk        (clk),
        .reset      (reset),
        .start      (start_s),
        .rs_addr    (rs_addr_s),
        .rs_data    (rs_data_s),
        .dump_valid (valid_s),
        .dump_ready (ready_s),
        .dump_index (index_s),
        .dump_data  (data_s),
        .dump_last  (last_s),
        .hold_cpu   (hold_s),
        .busy       (busy_s),
        .done       (done_s)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected stream: one beat per register in order, then the XOR beat if enabled.
    function automatic int model_len(input int first, input int last);
        return last - first + 1 + (CSUM_EN ? 1 : 0);
    endfunction

    function automatic beat_t model_beat(input int first, input int last, input int n);
        beat_t             b;
        logic [DATA_W-1:0] x;
        b = '0;
        if (n <= last - first) begin
            b.idx  = ADDR_W'(first + n);
            b.data = bank[first + n];
            b.last = !CSUM_EN && (n == last - first);
        end else begin
            x = '0;
            for (int k = first; k <= last; k++) x ^= bank[k];
            b.idx  = '0;
            b.data = x;
            b.last = 1'b1;
        end
        return b;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        dump_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", dump_valid, 1);
                check_eq("stall_index", dump_index, prev_beat.idx);
                check_eq("stall_data", dump_data, prev_beat.data);
                check_eq("stall_last", dump_last, prev_beat.last);
            end
            if (busy && !prev_busy) first_read_cyc = cyc;
            if (dump_valid && dump_ready) begin
                check_eq("beat_in_range", m_beats < model_len(0, N_REGS - 1), 1);
                if (m_beats < model_len(0, N_REGS - 1)) begin
                    e = model_beat(0, N_REGS - 1, m_beats);
                    check_eq("beat_index", dump_index, e.idx);
                    check_eq("beat_data", dump_data, e.data);
                    check_eq("beat_last", dump_last, e.last);
                end
                m_beats++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                check_eq("done_no_beat", dump_valid, 0);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall     = dump_valid && !dump_ready;
            prev_beat.idx  = dump_index;
            prev_beat.data = dump_data;
            prev_beat.last = dump_last;
            prev_busy      = busy;
        end
    end

    // Called at posedge+1; extra_a/extra_b are cycles (after start) for ignored start pulses.
    task automatic run_dump(input string tag, input int extra_a, input int extra_b, input bit chk_lat);
        int base_done;
        int t;
        m_beats   = 0;
        base_done = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 1;
        while (done_cnt == base_done && t < 4000) begin
            start = (t == extra_a) || (t == extra_b);
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        check_eq({tag, "_timeout"}, done_cnt == base_done, 0);
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_beats"}, m_beats, model_len(0, N_REGS - 1));
        check_eq({tag, "_done_count"}, done_cnt - base_done, 1);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_hold"}, hold_cpu, 0);
        check_eq({tag, "_idle_valid"}, dump_valid, 0);
        if (chk_lat) begin
            check_eq({tag, "_latency"}, last_hs_cyc - first_read_cyc + 1,
                     2 * N_REGS + (CSUM_EN ? 2 : 0));
            check_eq({tag, "_done_delay"}, done_cyc - last_hs_cyc, 1);
        end
    endtask

    initial begin
        int    cnt;
        int    n1;
        int    d1;
        int    base_done;
        beat_t e;

        for (int k = 0; k < N_REGS; k++) bank[k] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", dump_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_hold", hold_cpu, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rs_addr", rs_addr, 0);
        check_eq("rst_index", dump_index, 0);
        check_eq("rst_data", dump_data, 0);
        check_eq("rst_last", dump_last, 0);
        check_eq("rst_single_valid", valid_s, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < N_REGS; k++) bank[k] = 32'(k * 32'h1111_1111);
        run_dump("seq", -1, -1, 1'b1);

        for (int k = 1; k < N_REGS; k++) bank[k] = $urandom;
        rnd_ready = 1'b1;
        run_dump("stall", -1, -1, 1'b0);
        rnd_ready = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < N_REGS; k++) bank[k] = 32'(k * 32'h1111_1111);
        run_dump("restart", 5, 20, 1'b1);

        // Reset during the 10th SEND cycle must abort cleanly.
        for (int k = 1; k < N_REGS; k++) bank[k] = $urandom;
        m_beats   = 0;
        base_done = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int t = 0; t < 200 && cnt < 10; t++) begin
            @(posedge clk); #1;
            if (dump_valid) cnt++;
        end
        check_eq("abort_send_reached", cnt, 10);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_valid", dump_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_hold", hold_cpu, 0);
        check_eq("abort_rs_addr", rs_addr, 0);
        check_eq("abort_done", done, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt - base_done, 0);
        run_dump("after_rst", -1, -1, 1'b1);

        bank[7] = 32'hDEAD_BEEF;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        n1 = 0;
        d1 = 0;
        for (int t = 0; t < 30; t++) begin
            if (valid_s) begin
                if (n1 < model_len(7, 7)) begin
                    e = model_beat(7, 7, n1);
                    check_eq("single_index", index_s, e.idx);
                    check_eq("single_data", data_s, e.data);
                    check_eq("single_last", last_s, e.last);
                end
                n1++;
            end
            if (done_s) begin
                check_eq("single_done_no_beat", valid_s, 0);
                d1++;
            end
            @(posedge clk); #1;
        end
        check_eq("single_beats", n1, model_len(7, 7));
        check_eq("single_done_count", d1, 1);
        check_eq("single_idle_busy", busy_s, 0);

        for (int k = 0; k < N_REGS; k++) bank[k] = 32'(k);
        run_dump("ramp", -1, -1, 1'b1);
        bank[5] = 32'h0000_00FF;
        run_dump("ramp_ff", -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
